dx_issue_ctrl: RTL and testbench

Issue and hazard controller on the write side of the decode-to-execute (D/X) pipeline latch.
- Decides each cycle whether the instruction in F/D advances into D/X, is held, or is replaced by a bubble (nop).
- Drives the enables and clears of the PC, F/D and D/X latches.
- Sequences multicycle mul/div so the instruction held in D/X stays stable until the multdiv unit reports ready.
- Sits between the decode stage, the PC/F-D/D-X latches, and the execute-stage branch and multdiv logic.

---
 rtl/processor_pkg.sv | 55 +++++
 rtl/dx_hazard_detect.sv | 72 +++++++
 rtl/dx_issue_ctrl.sv | 141 ++++++++++++++
 tb/tb_dx_issue_ctrl.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/processor_pkg.sv
// Shared decode constants for the D/X issue controller: instruction field
// positions, opcode and aluop encodings, and the issue FSM state encoding.
package processor_pkg;

    // Instruction field positions
    localparam int OP_MSB    = 31;
    localparam int OP_LSB    = 27;
    localparam int RD_MSB    = 26;
    localparam int RD_LSB    = 22;
    localparam int RS_MSB    = 21;
    localparam int RS_LSB    = 17;
    localparam int RT_MSB    = 16;
    localparam int RT_LSB    = 12;
    localparam int ALUOP_MSB = 6;
    localparam int ALUOP_LSB = 2;

    // Opcodes
    localparam logic [4:0] OP_R    = 5'b00000;
    localparam logic [4:0] OP_BNE  = 5'b00010;
    localparam logic [4:0] OP_JR   = 5'b00100;
    localparam logic [4:0] OP_ADDI = 5'b00101;
    localparam logic [4:0] OP_BLT  = 5'b00110;
    localparam logic [4:0] OP_SW   = 5'b00111;
    localparam logic [4:0] OP_LW   = 5'b01000;

    // R-type aluop codes that need the multicycle unit
    localparam logic [4:0] ALU_MUL = 5'b00110;
    localparam logic [4:0] ALU_DIV = 5'b00111;

    typedef enum logic [0:0] {
        ST_RUN     = 1'b0,
        ST_MD_BUSY = 1'b1
    } dx_state_e;

    function automatic logic [4:0] ir_opcode(input logic [31:0] ir);
        return ir[OP_MSB:OP_LSB];
    endfunction

    function automatic logic [4:0] ir_rd(input logic [31:0] ir);
        return ir[RD_MSB:RD_LSB];
    endfunction

    function automatic logic [4:0] ir_rs(input logic [31:0] ir);
        return ir[RS_MSB:RS_LSB];
    endfunction

    function automatic logic [4:0] ir_rt(input logic [31:0] ir);
        return ir[RT_MSB:RT_LSB];
    endfunction

    function automatic logic [4:0] ir_aluop(input logic [31:0] ir);
        return ir[ALUOP_MSB:ALUOP_LSB];
    endfunction

endpackage

// File: rtl/dx_hazard_detect.sv
// Combinational hazard detection between the F/D and D/X instructions:
// flags a load-use dependency and a mul/div sitting in D/X.
module dx_hazard_detect
    import processor_pkg::*;
(
    input  logic [31:0] fd_ir,
    input  logic [31:0] dx_ir,
    output logic        load_use,
    output logic        is_multdiv
);

    logic [4:0] fd_op;
    logic [4:0] fd_rd;
    logic [4:0] fd_rs;
    logic [4:0] fd_rt;
    logic [4:0] dx_op;
    logic [4:0] dx_rd;
    logic [4:0] dx_aluop;
    logic       reads_rd;
    logic       reads_rs;
    logic       reads_rt;
    logic       dx_is_lw;

    assign fd_op    = ir_opcode(fd_ir);
    assign fd_rd    = ir_rd(fd_ir);
    assign fd_rs    = ir_rs(fd_ir);
    assign fd_rt    = ir_rt(fd_ir);
    assign dx_op    = ir_opcode(dx_ir);
    assign dx_rd    = ir_rd(dx_ir);
    assign dx_aluop = ir_aluop(dx_ir);

    // Low-order immediate/shamt bits do not take part in hazard decisions.
    logic unused_ir_bits;
    assign unused_ir_bits = ^{fd_ir[11:0], dx_ir[21:7], dx_ir[1:0]};

    // Which register fields the F/D instruction actually reads.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned and infers a latch.
        reads_rd = 1'b0;
        reads_rs = 1'b0;
        reads_rt = 1'b0;
        unique case (fd_op)
            OP_R: begin
                reads_rs = 1'b1;
                reads_rt = 1'b1;
            end
            OP_ADDI, OP_LW: begin
                reads_rs = 1'b1;
            end
            OP_SW, OP_BNE, OP_BLT: begin
                reads_rd = 1'b1;
                reads_rs = 1'b1;
            end
            OP_JR: begin
                reads_rd = 1'b1;
            end
            default: ;
        endcase
    end

    // A load into $0 never creates a dependency, so rd != 0 gates the match.
    assign dx_is_lw = (dx_op == OP_LW) && (dx_rd != 5'd0);

    assign load_use = dx_is_lw &&
                      ((reads_rd && (fd_rd == dx_rd)) ||
                       (reads_rs && (fd_rs == dx_rd)) ||
                       (reads_rt && (fd_rt == dx_rd)));

    assign is_multdiv = (dx_op == OP_R) &&
                        ((dx_aluop == ALU_MUL) || (dx_aluop == ALU_DIV));

endmodule

// File: rtl/dx_issue_ctrl.sv
// Issue and hazard controller on the write side of the D/X latch.
// Decides advance / hold / bubble for the F/D instruction, drives the PC,
// F/D and D/X latch controls, and holds a mul/div in D/X until the multdiv
// unit reports ready, an exception, or the cycle budget expires.
// Optional build macro: DX_STALL_COUNT_EN enables the saturating
// stall-cycle counter on stall_cycles; otherwise stall_cycles is 0.
module dx_issue_ctrl
    import processor_pkg::*;
#(
    parameter int MD_TIMEOUT = 40,
    parameter int CNT_W      = 6
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] fd_ir,
    input  logic [31:0] dx_ir,
    input  logic        branch_taken,
    input  logic        md_ready,
    input  logic        md_exception,
    output logic        pc_ena,
    output logic        fd_ena,
    output logic        fd_flush,
    output logic        dx_ena,
    output logic        dx_bubble,
    output logic        md_start,
    output logic        md_timeout,
    output logic [31:0] stall_cycles
);

    if ((1 << CNT_W) <= MD_TIMEOUT) begin : g_cnt_w_check
        $error("CNT_W too small for MD_TIMEOUT");
    end

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MD_TIMEOUT - 1);

    dx_state_e        state_q;
    dx_state_e        state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             load_use;
    logic             is_multdiv;

    dx_hazard_detect u_hazard (
        .fd_ir      (fd_ir),
        .dx_ir      (dx_ir),
        .load_use   (load_use),
        .is_multdiv (is_multdiv)
    );

    // Output decode and next state; outputs react in the same cycle as the
    // hazard or branch so the latches capture the right value at the edge.
    always_comb begin
        pc_ena     = 1'b1;
        fd_ena     = 1'b1;
        fd_flush   = 1'b0;
        dx_ena     = 1'b1;
        dx_bubble  = 1'b0;
        md_start   = 1'b0;
        md_timeout = 1'b0;
        state_d    = state_q;
        cnt_d      = cnt_q;

        if (reset) begin
            pc_ena    = 1'b0;
            fd_ena    = 1'b0;
            fd_flush  = 1'b1;
            dx_bubble = 1'b1;
            state_d   = ST_RUN;
            cnt_d     = '0;
        end else begin
            unique case (state_q)
                ST_RUN: begin
                    if (branch_taken) begin
                        // Squash both younger instructions; the redirect wins over any stall.
                        fd_flush  = 1'b1;
                        dx_bubble = 1'b1;
                    end else if (is_multdiv) begin
                        md_start = 1'b1;
                        pc_ena   = 1'b0;
                        fd_ena   = 1'b0;
                        dx_ena   = 1'b0;
                        state_d  = ST_MD_BUSY;
                        cnt_d    = '0;
                    end else if (load_use) begin
                        pc_ena    = 1'b0;
                        fd_ena    = 1'b0;
                        dx_bubble = 1'b1;
                    end
                end
                ST_MD_BUSY: begin
                    pc_ena = 1'b0;
                    fd_ena = 1'b0;
                    dx_ena = 1'b0;
                    cnt_d  = cnt_q + 1'b1;
                    if (md_ready || md_exception || (cnt_q == CNT_LAST)) begin
                        // Replace the finished mul/div with a nop so it is not reissued.
                        dx_ena     = 1'b1;
                        dx_bubble  = 1'b1;
                        md_timeout = !md_ready && !md_exception;
                        state_d    = ST_RUN;
                        cnt_d      = '0;
                    end
                end
                default: begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // FSM state and multdiv cycle counter.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            state_q <= ST_RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef DX_STALL_COUNT_EN
    logic [31:0] stall_q;

    // Saturating count of cycles in which the PC is held.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_q <= '0;
        end else if (!pc_ena && (stall_q != 32'hFFFF_FFFF)) begin
            stall_q <= stall_q + 32'd1;
        end
    end

    assign stall_cycles = stall_q;
`else
    assign stall_cycles = '0;
`endif

endmodule

// File: tb/tb_dx_issue_ctrl.sv
// Self-checking bench for dx_issue_ctrl: each driven cycle pushes its
// expected outputs to a scoreboard queue; the falling edge pops and compares.
module tb_dx_issue_ctrl;

    localparam int MD_TO = 40;

    localparam logic [31:0] NOP      = 32'h0000_0000;
    localparam logic [31:0] LW5      = 32'h4144_0000; // lw  $5,0($2)
    localparam logic [31:0] LW0      = 32'h4004_0000; // lw  $0,0($2)
    localparam logic [31:0] ADD_RS5  = 32'h018A_1000; // add $6,$5,$1
    localparam logic [31:0] ADD_RT5  = 32'h0182_5000; // add $6,$1,$5
    localparam logic [31:0] ADD_R71  = 32'h018E_1000; // add $6,$7,$1
    localparam logic [31:0] ADD_R01  = 32'h0180_1000; // add $6,$0,$1
    localparam logic [31:0] SW_RD5   = 32'h3946_0000; // sw  $5,0($3)
    localparam logic [31:0] JR5      = 32'h2140_0000; // jr  $5
    localparam logic [31:0] J_RD5    = 32'h0940_0000; // opcode 00001, reads nothing
    localparam logic [31:0] MUL312   = 32'h00C2_2018; // mul $3,$1,$2
    localparam logic [31:0] DIV312   = 32'h00C2_201C; // div $3,$1,$2

    typedef enum int {K_RESET, K_RUN, K_FLUSH, K_MDSTART, K_LOADUSE, K_BUSY, K_EXIT, K_TIMEOUT} kind_e;

    typedef struct {
        string       tag;
        logic [6:0]  outs;
        logic        chk_stall;
        logic [31:0] stall;
    } exp_t;

    logic        clk;
    logic        reset;
    logic [31:0] fd_ir;
    logic [31:0] dx_ir;
    logic        branch_taken;
    logic        md_ready;
    logic        md_exception;
    logic        pc_ena;
    logic        fd_ena;
    logic        fd_flush;
    logic        dx_ena;
    logic        dx_bubble;
    logic        md_start;
    logic        md_timeout;
    logic [31:0] stall_cycles;

    int          checks = 0;
    int          errors = 0;
    exp_t        sb_q[$];
    logic [31:0] model_stalls = '0;

    dx_issue_ctrl dut (
        .clk          (clk),
        .reset        (reset),
        .fd_ir        (fd_ir),
        .dx_ir        (dx_ir),
        .branch_taken (branch_taken),
        .md_ready     (md_ready),
        .md_exception (md_exception),
        .pc_ena       (pc_ena),
        .fd_ena       (fd_ena),
        .fd_flush     (fd_flush),
        .dx_ena       (dx_ena),
        .dx_bubble    (dx_bubble),
        .md_start     (md_start),
        .md_timeout   (md_timeout),
        .stall_cycles (stall_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    // Expected {pc_ena, fd_ena, fd_flush, dx_ena, dx_bubble, md_start, md_timeout}.
    function automatic logic [6:0] kind_outs(input kind_e k);
        case (k)
            K_RESET:   return 7'b0011100;
            K_RUN:     return 7'b1101000;
            K_FLUSH:   return 7'b1111100;
            K_MDSTART: return 7'b0000010;
            K_LOADUSE: return 7'b0001100;
            K_BUSY:    return 7'b0000000;
            K_EXIT:    return 7'b0001100;
            K_TIMEOUT: return 7'b0001101;
            default:   return 7'b1111111;
        endcase
    endfunction

    // Drive one cycle of stimulus and record what the DUT must show for it.
    task automatic drive(input string tag, input logic rst, input logic [31:0] fd, input logic [31:0] dx,
                         input logic br, input logic rdy, input logic exc, input kind_e k);
        exp_t e;
        @(posedge clk);
        #1;
        reset        = rst;
        fd_ir        = fd;
        dx_ir        = dx;
        branch_taken = br;
        md_ready     = rdy;
        md_exception = exc;
        e.tag       = tag;
        e.outs      = kind_outs(k);
        e.chk_stall = !rst;
`ifdef DX_STALL_COUNT_EN
        e.stall = model_stalls;
        if (rst) model_stalls = '0;
        else if (!e.outs[6]) model_stalls = model_stalls + 32'd1;
`else
        e.stall = '0;
`endif
        sb_q.push_back(e);
    endtask

    // Scoreboard consumer, sampling away from the active edge.
    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            exp_t e;
            e = sb_q.pop_front();
            check({e.tag, "_outs"}, {25'd0, pc_ena, fd_ena, fd_flush, dx_ena, dx_bubble, md_start, md_timeout},
                  {25'd0, e.outs});
            if (e.chk_stall) check({e.tag, "_stall"}, stall_cycles, e.stall);
        end
    end

    initial begin
        reset        = 1'b1;
        fd_ir        = NOP;
        dx_ir        = NOP;
        branch_taken = 1'b0;
        md_ready     = 1'b0;
        md_exception = 1'b0;

        drive("reset0", 1, ADD_RS5, LW5, 0, 0, 0, K_RESET);
        drive("reset1", 1, ADD_RS5, MUL312, 1, 0, 0, K_RESET);
        drive("run",    0, ADD_RS5, NOP, 0, 0, 0, K_RUN);

        // Load-use detection on each kind of source field
        drive("lu_rs",     0, ADD_RS5, LW5, 0, 0, 0, K_LOADUSE);
        drive("lu_rs_adv", 0, ADD_RS5, NOP, 0, 0, 0, K_RUN);
        drive("lu_rt",     0, ADD_RT5, LW5, 0, 0, 0, K_LOADUSE);
        drive("lu_sw_rd",  0, SW_RD5,  LW5, 0, 0, 0, K_LOADUSE);
        drive("lu_jr_rd",  0, JR5,     LW5, 0, 0, 0, K_LOADUSE);
        drive("no_src",    0, J_RD5,   LW5, 0, 0, 0, K_RUN);
        drive("no_match",  0, ADD_R71, LW5, 0, 0, 0, K_RUN);
        drive("reg0",      0, ADD_R01, LW0, 0, 0, 0, K_RUN);

        // Branch overrides a pending load-use stall
        drive("br_prio",   0, ADD_RS5, LW5, 1, 0, 0, K_FLUSH);
        drive("br_plain",  0, ADD_R71, NOP, 1, 0, 0, K_FLUSH);

        // Mul with ready five cycles after start
        drive("mul_start", 0, ADD_RS5, MUL312, 0, 0, 0, K_MDSTART);
        for (int i = 1; i <= 4; i++) drive($sformatf("mul_busy%0d", i), 0, ADD_RS5, MUL312, 0, 0, 0, K_BUSY);
        drive("mul_exit",  0, ADD_RS5, MUL312, 0, 1, 0, K_EXIT);
        drive("mul_after", 0, ADD_RS5, NOP, 0, 0, 0, K_RUN);

        // Div ending on an exception
        drive("div_start", 0, ADD_R71, DIV312, 0, 0, 0, K_MDSTART);
        drive("div_busy",  0, ADD_R71, DIV312, 0, 0, 0, K_BUSY);
        drive("div_exc",   0, ADD_R71, DIV312, 0, 0, 1, K_EXIT);
        drive("div_after", 0, ADD_R71, NOP, 0, 0, 0, K_RUN);

        // Forced exit after MD_TO busy cycles
        drive("to_start", 0, ADD_R71, MUL312, 0, 0, 0, K_MDSTART);
        for (int i = 1; i < MD_TO; i++) drive($sformatf("to_busy%0d", i), 0, ADD_R71, MUL312, 0, 0, 0, K_BUSY);
        drive("to_fire",  0, ADD_R71, MUL312, 0, 0, 0, K_TIMEOUT);
        drive("to_after", 0, ADD_R71, NOP, 0, 0, 0, K_RUN);

        // Ready in the timeout cycle counts as ready
        drive("rt_start", 0, ADD_R71, MUL312, 0, 0, 0, K_MDSTART);
        for (int i = 1; i < MD_TO; i++) drive($sformatf("rt_busy%0d", i), 0, ADD_R71, MUL312, 0, 0, 0, K_BUSY);
        drive("rt_ready", 0, ADD_R71, MUL312, 0, 1, 0, K_EXIT);
        drive("rt_after", 0, ADD_R71, NOP, 0, 0, 0, K_RUN);

        // Reset in MD_BUSY cycle 3
        drive("rb_start", 0, ADD_R71, MUL312, 0, 0, 0, K_MDSTART);
        drive("rb_busy1", 0, ADD_R71, MUL312, 0, 0, 0, K_BUSY);
        drive("rb_busy2", 0, ADD_R71, MUL312, 0, 0, 0, K_BUSY);
        drive("rb_reset", 1, ADD_R71, MUL312, 0, 0, 0, K_RESET);
        drive("rb_run",   0, ADD_R71, NOP, 0, 0, 0, K_RUN);
        drive("rb_lu",    0, ADD_RS5, LW5, 0, 0, 0, K_LOADUSE);
        drive("rb_end",   0, ADD_RS5, NOP, 0, 0, 0, K_RUN);

        repeat (2) @(negedge clk);
        check("sb_drain", 32'(sb_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
